// File: rtl/hft_macd_engine_mc_if.sv
// Tick-in / order-out bundle of the multi-channel MACD engine.
// The engine connects through the slave modport, the feed/order side through master.
interface hft_macd_engine_mc_if #(
   parameter int N_CH    = 4,
   parameter int PRICE_W = 32
);
   localparam int CH_W = $clog2(N_CH);

   logic                      tick_valid;
   logic                      tick_ready;
   logic [CH_W-1:0]           tick_ch;
   logic signed [PRICE_W-1:0] tick_price;
   logic                      trade_en;
   logic                      order_valid;
   logic                      order_ready;
   logic [CH_W-1:0]           order_ch;
   logic [1:0]                order_side;
   logic signed [PRICE_W-1:0] order_price;

   modport master (
      output tick_valid, tick_ch, tick_price, trade_en, order_ready,
      input  tick_ready, order_valid, order_ch, order_side, order_price
   );

   modport slave (
      input  tick_valid, tick_ch, tick_price, trade_en, order_ready,
      output tick_ready, order_valid, order_ch, order_side, order_price
   );
endinterface

// File: rtl/hft_macd_engine_mc.sv
// Time-shared MACD alpha engine: per-channel fast/slow/signal EMAs and position
// state, one tick at a time through IDLE -> EMA -> SIG -> DECIDE (-> EMIT).
module hft_macd_engine_mc #(
   parameter int N_CH            = 4,
   parameter int PRICE_W         = 32,
   parameter int FRAC_W          = 16,
   parameter int ALPHA_FAST      = 10181,
   parameter int ALPHA_SLOW      = 4854,
   parameter int ALPHA_SIG       = 13107,
   parameter int HYST            = 0,
   parameter int WARMUP_TICKS    = 26,
   parameter int STOP_LOSS_PTS   = 50,
   parameter int TAKE_PROFIT_PTS = 100
) (
   input logic                 clk,
   input logic                 reset,
   hft_macd_engine_mc_if.slave bus
);
   localparam int CH_W   = $clog2(N_CH);
   localparam int Q_W    = PRICE_W + FRAC_W + 2;
   localparam int P_W    = Q_W + FRAC_W + 2;
   localparam int WARM_W = $clog2(WARMUP_TICKS + 1);

   localparam logic signed [FRAC_W:0]  A_FAST   = (FRAC_W+1)'(ALPHA_FAST);
   localparam logic signed [FRAC_W:0]  A_SLOW   = (FRAC_W+1)'(ALPHA_SLOW);
   localparam logic signed [FRAC_W:0]  A_SIG    = (FRAC_W+1)'(ALPHA_SIG);
   localparam logic signed [Q_W-1:0]   HYST_Q   = Q_W'(HYST);
   localparam logic signed [PRICE_W:0] SL_PTS   = (PRICE_W+1)'(STOP_LOSS_PTS);
   localparam logic signed [PRICE_W:0] TP_PTS   = (PRICE_W+1)'(TAKE_PROFIT_PTS);
   localparam logic [WARM_W-1:0]       WARM_MAX = WARM_W'(WARMUP_TICKS);

   typedef enum logic [2:0] {S_IDLE, S_EMA, S_SIG, S_DECIDE, S_EMIT} state_e;
   typedef enum logic [1:0] {POS_FLAT, POS_LONG, POS_SHORT} pos_e;

   // acc + floor((tgt - acc) * alpha / 2^FRAC_W), product kept at full width
   function automatic logic signed [Q_W-1:0] ema_step(
      input logic signed [Q_W-1:0]  acc,
      input logic signed [Q_W-1:0]  tgt,
      input logic signed [FRAC_W:0] alpha
   );
      logic signed [P_W-1:0] prod;
      logic signed [P_W-1:0] shifted;
      prod    = (tgt - acc) * alpha;
      shifted = prod >>> FRAC_W;
      return acc + $signed(shifted[Q_W-1:0]);
   endfunction

   logic signed [Q_W-1:0]     fast_q  [N_CH];
   logic signed [Q_W-1:0]     fast_d  [N_CH];
   logic signed [Q_W-1:0]     slow_q  [N_CH];
   logic signed [Q_W-1:0]     slow_d  [N_CH];
   logic signed [Q_W-1:0]     sig_q   [N_CH];
   logic signed [Q_W-1:0]     sig_d   [N_CH];
   logic [WARM_W-1:0]         warm_q  [N_CH];
   logic [WARM_W-1:0]         warm_d  [N_CH];
   pos_e                      pos_q   [N_CH];
   pos_e                      pos_d   [N_CH];
   logic signed [PRICE_W-1:0] entry_q [N_CH];
   logic signed [PRICE_W-1:0] entry_d [N_CH];
   logic [N_CH-1:0]           seen_q, seen_d;

   state_e                    state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic signed [PRICE_W-1:0] px_q, px_d;
   logic signed [Q_W-1:0]     hist_q, hist_d;
   logic [CH_W-1:0]           och_q, och_d;
   logic [1:0]                oside_q, oside_d;
   logic signed [PRICE_W-1:0] opx_q, opx_d;

   logic signed [Q_W-1:0]     px_fx, macd, sig_new;
   logic signed [PRICE_W:0]   move_up, move_dn;
   logic                      is_long, is_short, is_flat, hist_pos, hist_neg;
   logic                      hit;
   logic [1:0]                side;

   assign px_fx    = {{(Q_W-PRICE_W-FRAC_W){px_q[PRICE_W-1]}}, px_q, {FRAC_W{1'b0}}};
   assign macd     = fast_q[ch_q] - slow_q[ch_q];
   assign sig_new  = ema_step(sig_q[ch_q], macd, A_SIG);
   assign move_up  = $signed({px_q[PRICE_W-1], px_q}) -
                     $signed({entry_q[ch_q][PRICE_W-1], entry_q[ch_q]});
   assign move_dn  = $signed({entry_q[ch_q][PRICE_W-1], entry_q[ch_q]}) -
                     $signed({px_q[PRICE_W-1], px_q});
   assign is_long  = (pos_q[ch_q] == POS_LONG);
   assign is_short = (pos_q[ch_q] == POS_SHORT);
   assign is_flat  = (pos_q[ch_q] == POS_FLAT);
   assign hist_pos = (hist_q > HYST_Q);
   assign hist_neg = (hist_q < -HYST_Q);

   assign bus.tick_ready  = (state_q == S_IDLE) && !reset;
   assign bus.order_valid = (state_q == S_EMIT);
   assign bus.order_ch    = och_q;
   assign bus.order_side  = oside_q;
   assign bus.order_price = opx_q;

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      px_d    = px_q;
      hist_d  = hist_q;
      och_d   = och_q;
      oside_d = oside_q;
      opx_d   = opx_q;
      fast_d  = fast_q;
      slow_d  = slow_q;
      sig_d   = sig_q;
      warm_d  = warm_q;
      pos_d   = pos_q;
      entry_d = entry_q;
      seen_d  = seen_q;
      hit     = 1'b0;
      side    = 2'b00;
      unique case (state_q)
         S_IDLE: begin
            if (bus.tick_valid) begin
               ch_d    = bus.tick_ch;
               px_d    = bus.tick_price;
               state_d = S_EMA;
            end
         end
         S_EMA: begin
            // A channel's first tick only seeds its EMAs.
            if (!seen_q[ch_q]) begin
               fast_d[ch_q] = px_fx;
               slow_d[ch_q] = px_fx;
               sig_d[ch_q]  = '0;
               seen_d[ch_q] = 1'b1;
               warm_d[ch_q] = WARM_W'(1);
               state_d      = S_IDLE;
            end else begin
               fast_d[ch_q] = ema_step(fast_q[ch_q], px_fx, A_FAST);
               slow_d[ch_q] = ema_step(slow_q[ch_q], px_fx, A_SLOW);
               state_d      = S_SIG;
            end
         end
         S_SIG: begin
            sig_d[ch_q] = sig_new;
            hist_d      = macd - sig_new;
            if (warm_q[ch_q] < WARM_MAX) warm_d[ch_q] = warm_q[ch_q] + 1'b1;
            state_d     = S_DECIDE;
         end
         S_DECIDE: begin
            state_d = S_IDLE;
            if (warm_q[ch_q] >= WARM_MAX) begin
               hit  = 1'b1;
               side = 2'b11;
               if ((is_long && move_dn >= SL_PTS) || (is_short && move_up >= SL_PTS)) begin
                  pos_d[ch_q] = POS_FLAT;
               end else if (TP_PTS != 0 &&
                            ((is_long && move_up >= TP_PTS) || (is_short && move_dn >= TP_PTS))) begin
                  pos_d[ch_q] = POS_FLAT;
               end else if (is_long && hist_neg) begin
                  side        = 2'b10;
                  pos_d[ch_q] = POS_FLAT;
               end else if (is_short && hist_pos) begin
                  side        = 2'b01;
                  pos_d[ch_q] = POS_FLAT;
               end else if (is_flat && bus.trade_en && hist_pos) begin
                  side          = 2'b01;
                  pos_d[ch_q]   = POS_LONG;
                  entry_d[ch_q] = px_q;
               end else if (is_flat && bus.trade_en && hist_neg) begin
                  side          = 2'b10;
                  pos_d[ch_q]   = POS_SHORT;
                  entry_d[ch_q] = px_q;
               end else begin
                  hit = 1'b0;
               end
               if (hit) begin
                  och_d   = ch_q;
                  oside_d = side;
                  opx_d   = px_q;
                  state_d = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (bus.order_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         px_q    <= '0;
         hist_q  <= '0;
         och_q   <= '0;
         oside_q <= '0;
         opx_q   <= '0;
         seen_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            fast_q[i]  <= '0;
            slow_q[i]  <= '0;
            sig_q[i]   <= '0;
            warm_q[i]  <= '0;
            pos_q[i]   <= POS_FLAT;
            entry_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         px_q    <= px_d;
         hist_q  <= hist_d;
         och_q   <= och_d;
         oside_q <= oside_d;
         opx_q   <= opx_d;
         seen_q  <= seen_d;
         fast_q  <= fast_d;
         slow_q  <= slow_d;
         sig_q   <= sig_d;
         warm_q  <= warm_d;
         pos_q   <= pos_d;
         entry_q <= entry_d;
      end
   end
endmodule

// File: tb/tb_hft_macd_engine_mc.sv
// Directed and randomized bench for hft_macd_engine_mc with an arithmetic reference model.
module tb_hft_macd_engine_mc;
   localparam int N_CH    = 4;
   localparam int PRICE_W = 32;
   localparam int FRAC_W  = 16;
   localparam int A_FAST  = 10181;
   localparam int A_SLOW  = 4854;
   localparam int A_SIG   = 13107;
   localparam int HYST    = 0;
   localparam int WARM    = 3;
   localparam int SL      = 50;
   localparam int TP      = 100;

   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   hft_macd_engine_mc_if #(.N_CH(N_CH), .PRICE_W(PRICE_W)) bus ();

   hft_macd_engine_mc #(
      .N_CH(N_CH), .PRICE_W(PRICE_W), .FRAC_W(FRAC_W),
      .ALPHA_FAST(A_FAST), .ALPHA_SLOW(A_SLOW), .ALPHA_SIG(A_SIG),
      .HYST(HYST), .WARMUP_TICKS(WARM), .STOP_LOSS_PTS(SL), .TAKE_PROFIT_PTS(TP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: per-channel state as plain numbers.
   logic signed [127:0] m_fast [N_CH];
   logic signed [127:0] m_slow [N_CH];
   logic signed [127:0] m_sig  [N_CH];
   bit                  m_seen [N_CH];
   int                  m_warm [N_CH];
   int                  m_pos  [N_CH];   // 0 flat, 1 long, 2 short
   longint              m_entry[N_CH];

   function automatic logic signed [127:0] ema(input logic signed [127:0] old,
                                               input logic signed [127:0] tgt,
                                               input int a);
      logic signed [127:0] av;
      av = a;
      return old + (((tgt - old) * av) >>> FRAC_W);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_fast[i] = 0; m_slow[i] = 0; m_sig[i] = 0;
         m_seen[i] = 0; m_warm[i] = 0; m_pos[i] = 0; m_entry[i] = 0;
      end
   endtask

   task automatic model_tick(input int ch, input int price, input bit te,
                             output bit ev, output logic [1:0] es);
      logic signed [127:0] pq, macd, hist;
      longint up;
      ev = 1'b0;
      es = 2'b00;
      pq = price;
      pq = pq * (128'sd1 << FRAC_W);
      if (!m_seen[ch]) begin
         m_fast[ch] = pq; m_slow[ch] = pq; m_sig[ch] = 0;
         m_seen[ch] = 1;  m_warm[ch] = 1;
         return;
      end
      m_fast[ch] = ema(m_fast[ch], pq, A_FAST);
      m_slow[ch] = ema(m_slow[ch], pq, A_SLOW);
      macd       = m_fast[ch] - m_slow[ch];
      m_sig[ch]  = ema(m_sig[ch], macd, A_SIG);
      hist       = macd - m_sig[ch];
      if (m_warm[ch] < WARM) m_warm[ch]++;
      if (m_warm[ch] < WARM) return;
      up = longint'(price) - m_entry[ch];
      if (m_pos[ch] == 1 && -up >= SL) begin es = 2'b11; m_pos[ch] = 0; end
      else if (m_pos[ch] == 2 && up >= SL) begin es = 2'b11; m_pos[ch] = 0; end
      else if (TP != 0 && ((m_pos[ch] == 1 && up >= TP) || (m_pos[ch] == 2 && -up >= TP))) begin
         es = 2'b11; m_pos[ch] = 0;
      end
      else if (m_pos[ch] == 1 && hist < -HYST) begin es = 2'b10; m_pos[ch] = 0; end
      else if (m_pos[ch] == 2 && hist > HYST) begin es = 2'b01; m_pos[ch] = 0; end
      else if (m_pos[ch] == 0 && te && hist > HYST) begin
         es = 2'b01; m_pos[ch] = 1; m_entry[ch] = price;
      end
      else if (m_pos[ch] == 0 && te && hist < -HYST) begin
         es = 2'b10; m_pos[ch] = 2; m_entry[ch] = price;
      end
      ev = (es != 2'b00);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // want: -1 = model only, else required side (0 = no order).
   // hold: cycles of order_ready=0 before accepting; negative = reset while emitting.
   task automatic do_tick(input int ch, input int price, input bit te, input int want, input int hold);
      int         n;
      bit         ev, first;
      logic [1:0] es;
      logic [63:0] obs_side;
      first = !m_seen[ch];
      @(negedge clk);
      n = 0;
      while (bus.tick_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("tick_ready_wait", {63'd0, bus.tick_ready}, 64'd1);
      bus.trade_en   = te;
      bus.tick_ch    = 2'(ch);
      bus.tick_price = price;
      bus.tick_valid = 1'b1;
      @(posedge clk);
      #1 bus.tick_valid = 1'b0;
      model_tick(ch, price, te, ev, es);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c < 4) check("no_early_order", {63'd0, bus.order_valid}, 64'd0);
         if (first && c == 2) check("first_tick_ready", {63'd0, bus.tick_ready}, 64'd1);
      end
      check("order_valid_t4", {63'd0, bus.order_valid}, {63'd0, ev});
      obs_side = bus.order_valid ? {62'd0, bus.order_side} : 64'd0;
      if (want >= 0) check("directed_side", obs_side, 64'(want));
      if (!ev) begin
         check("ready_after_noorder", {63'd0, bus.tick_ready}, 64'd1);
         return;
      end
      check("order_ch", {62'd0, bus.order_ch}, 64'(ch));
      check("order_side", {62'd0, bus.order_side}, {62'd0, es});
      check("order_price", {32'd0, bus.order_price}, {32'd0, price[31:0]});
      if (hold < 0) begin
         #2 reset = 1'b1;
         #1;
         check("async_rst_valid", {63'd0, bus.order_valid}, 64'd0);
         check("async_rst_ready", {63'd0, bus.tick_ready}, 64'd0);
         check("async_rst_side", {62'd0, bus.order_side}, 64'd0);
         model_reset();
         @(negedge clk);
         reset = 1'b0;
         return;
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("bp_valid", {63'd0, bus.order_valid}, 64'd1);
         check("bp_payload", {28'd0, bus.order_ch, bus.order_side, bus.order_price},
               {28'd0, 2'(ch), es, price[31:0]});
         check("bp_tick_ready", {63'd0, bus.tick_ready}, 64'd0);
      end
      bus.order_ready = 1'b1;
      @(posedge clk);
      #1 bus.order_ready = 1'b0;
      @(negedge clk);
      check("post_hs_valid", {63'd0, bus.order_valid}, 64'd0);
      check("post_hs_ready", {63'd0, bus.tick_ready}, 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur [N_CH];
      int ch, price;
      model_reset();
      reset           = 1'b1;
      bus.tick_valid  = 1'b1;
      bus.tick_ch     = '0;
      bus.tick_price  = 1000;
      bus.trade_en    = 1'b1;
      bus.order_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tick_ready", {63'd0, bus.tick_ready}, 64'd0);
      check("rst_order_valid", {63'd0, bus.order_valid}, 64'd0);
      reset = 1'b0;
      #1;
      check("rel_tick_ready", {63'd0, bus.tick_ready}, 64'd1);
      check("rel_order_payload", {28'd0, bus.order_ch, bus.order_side, bus.order_price}, 64'd0);
      bus.tick_valid = 1'b0;

      // warm-up then first entry on ch0
      do_tick(0, 1000, 1'b1, 0, 0);
      do_tick(0, 1001, 1'b1, 0, 0);
      do_tick(0, 1002, 1'b1, 1, 2);

      // ch1 long at 2000, stop-loss boundary, backpressured exit
      do_tick(1, 1000, 1'b1, 0, 0);
      do_tick(1, 1000, 1'b1, 0, 0);
      do_tick(1, 2000, 1'b1, 1, 0);
      do_tick(1, 1951, 1'b1, 0, 0);
      do_tick(1, 1950, 1'b1, 3, 10);

      // interleaved ramps with entries blocked, then allowed
      for (int k = 0; k < 4; k++) begin
         do_tick(2, 3000 + 10 * k, 1'b0, 0, 0);
         do_tick(3, 5000 - 10 * k, 1'b0, 0, 0);
      end
      do_tick(2, 3040, 1'b1, 1, 1);
      do_tick(3, 4960, 1'b1, 2, 0);

      // ch0 stop-loss order killed by reset, then ch0 starts over
      do_tick(0, 900, 1'b1, 3, -1);
      do_tick(0, 1000, 1'b1, 0, 0);

      for (int i = 0; i < N_CH; i++) cur[i] = 1000 * (i + 1);
      for (int t = 0; t < 150; t++) begin
         ch      = int'($urandom_range(0, N_CH - 1));
         cur[ch] = cur[ch] + int'($urandom_range(0, 80)) - 40;
         price   = cur[ch];
         do_tick(ch, price, ($urandom_range(0, 3) != 0), -1, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
